// File: rtl/trigger_unit.sv
// Trigger qualifier feeding the logic analyzer: pattern/mask, edge and occurrence-count match, gated by primed.
// Latency: o_trigger rises on the edge that samples the qualifying data (1 cycle from sample to output).
// Backpressure: none; firing waits for i_primed, i_arm=0 always wins and returns to IDLE.
module trigger_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_arm,
  input  logic                   i_force,
  input  logic                   i_primed,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [DATA_WIDTH-1:0]  i_pattern,
  input  logic [DATA_WIDTH-1:0]  i_mask,
  input  logic [DATA_WIDTH-1:0]  i_edge_mask,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic                   o_trigger,
  output logic                   o_armed,
  output logic [COUNT_WIDTH-1:0] o_match_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    FIRED = 2'b10
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_WIDTH-1:0]  pattern_q;
  logic [DATA_WIDTH-1:0]  mask_q;
  logic [DATA_WIDTH-1:0]  edge_mask_q;
  logic [DATA_WIDTH-1:0]  prev_data;
  logic                   prev_valid;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] match_cnt;
  logic [COUNT_WIDTH:0]   cnt_plus1;
  logic                   level_ok;
  logic                   edge_ok;
  logic                   qual;
  logic                   fire;

  // One extra bit so an all-ones count threshold is still reachable.
  assign cnt_plus1 = {1'b0, match_cnt} + {{COUNT_WIDTH{1'b0}}, 1'b1};

  assign level_ok = ((i_data ^ pattern_q) & mask_q) == '0;
  assign edge_ok  = (edge_mask_q == '0) ? 1'b1 :
                    (prev_valid && (((i_data ^ prev_data) & edge_mask_q) == edge_mask_q));
  assign qual     = (state == ARMED) && i_primed && level_ok && edge_ok;
  assign fire     = (state == ARMED) && i_primed &&
                    ((qual && (cnt_plus1 >= {1'b0, count_q})) || i_force);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_arm) state_nxt = ARMED;
      ARMED: begin
        if (!i_arm)    state_nxt = IDLE;
        else if (fire) state_nxt = FIRED;
      end
      FIRED:   if (!i_arm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_trigger   = (state == FIRED);
    o_armed     = (state == ARMED);
    o_match_cnt = match_cnt;
  end

  // Config is only sampled on the arm edge; mid-run changes wait for the next arm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q   <= '0;
      mask_q      <= '0;
      edge_mask_q <= '0;
      count_q     <= '0;
      prev_data   <= '0;
      prev_valid  <= 1'b0;
      match_cnt   <= '0;
    end else if (state == IDLE && i_arm) begin
      pattern_q   <= i_pattern;
      mask_q      <= i_mask;
      edge_mask_q <= i_edge_mask;
      count_q     <= (i_count == '0) ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : i_count;
      prev_valid  <= 1'b0;
      match_cnt   <= '0;
    end else if (state == ARMED) begin
      prev_data  <= i_data;
      prev_valid <= 1'b1;
      if (qual && match_cnt != '1) match_cnt <= cnt_plus1[COUNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_trigger_unit.sv
// Bench for trigger_unit: directed scenarios plus a randomized run against a behavioural model.
module tb_trigger_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic       frc = 1'b0;
  logic       primed = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] pattern = 8'h00;
  logic [7:0] mask = 8'h00;
  logic [7:0] edge_mask = 8'h00;
  logic [7:0] count = 8'h00;
  logic       trig;
  logic       armed;
  logic [7:0] mcnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: phase 0 = idle, 1 = waiting for matches, 2 = triggered.
  int         m_phase;
  int         m_cnt;
  int         m_need;
  logic [7:0] m_pat, m_msk, m_emsk, m_prev;
  bit         m_have_prev;

  trigger_unit #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .i_arm(arm), .i_force(frc), .i_primed(primed),
    .i_data(data), .i_pattern(pattern), .i_mask(mask), .i_edge_mask(edge_mask),
    .i_count(count), .o_trigger(trig), .o_armed(armed), .o_match_cnt(mcnt)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_need = 0;
    m_pat = 0; m_msk = 0; m_emsk = 0; m_prev = 0; m_have_prev = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit lvl, edg, hit, go;
    if (m_phase == 0) begin
      if (arm) begin
        m_phase = 1; m_pat = pattern; m_msk = mask; m_emsk = edge_mask;
        m_need = (count == 0) ? 1 : int'(count); m_cnt = 0; m_have_prev = 0;
      end
    end else if (m_phase == 2) begin
      if (!arm) m_phase = 0;
    end else begin
      lvl = ((data ^ m_pat) & m_msk) == 0;
      if (m_emsk == 0) edg = 1;
      else edg = m_have_prev && (((data ^ m_prev) & m_emsk) == m_emsk);
      hit = primed && lvl && edg;
      go  = primed && ((hit && (m_cnt + 1 >= m_need)) || frc);
      if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
      m_prev = data; m_have_prev = 1;
      if (!arm) m_phase = 0;
      else if (go) m_phase = 2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b want 0", armed); end
    n_tests++; if (mcnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %h want 00", mcnt); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    pattern = 8'hA5; mask = 8'hFF; edge_mask = 8'h00; count = 8'd1; primed = 1'b1;
    data = 8'h00; arm = 1'b1;
    cycle();
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed: got %b want 1", armed); end
    cycle();
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL basic_nomatch: got %b want 0", trig); end
    data = 8'hA5;
    cycle();
    n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL basic_fire: got %b want 1", trig); end
    n_tests++; if (mcnt !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", mcnt); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL basic_armed_fall: got %b want 0", armed); end
    arm = 1'b0;
    cycle();
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL basic_disarm: got %b want 0", trig); end
    n_tests++; if (mcnt !== 8'd1) begin n_fail++; $display("FAIL basic_cnt_hold: got %0d want 1", mcnt); end
  endtask

  task automatic test_mask_count();
    logic [7:0] seq [4];
    int         want_cnt [4];
    seq = '{8'h15, 8'h25, 8'h00, 8'h35};
    want_cnt = '{1, 2, 2, 3};
    pattern = 8'h05; mask = 8'h0F; count = 8'd3; arm = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      data = seq[i];
      cycle();
      n_tests++; if (trig !== (i == 3)) begin n_fail++; $display("FAIL mc_trig[%0d]: got %b want %b", i, trig, i == 3); end
      n_tests++; if (int'(mcnt) != want_cnt[i]) begin n_fail++; $display("FAIL mc_cnt[%0d]: got %0d want %0d", i, mcnt, want_cnt[i]); end
    end
    arm = 1'b0; cycle();
    count = 8'd0; arm = 1'b1; data = 8'h00;
    cycle();
    data = 8'h05;
    cycle();
    n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL count0_fire: got %b want 1", trig); end
    n_tests++; if (mcnt !== 8'd1) begin n_fail++; $display("FAIL count0_cnt: got %0d want 1", mcnt); end
    arm = 1'b0; cycle();
  endtask

  task automatic test_primed();
    pattern = 8'hA5; mask = 8'hFF; edge_mask = 8'h00; count = 8'd1;
    primed = 1'b0; arm = 1'b1;
    cycle();
    data = 8'hA5;
    repeat (4) cycle();
    primed = 1'b1; data = 8'h00;
    cycle();
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL primed_gate_trig: got %b want 0", trig); end
    n_tests++; if (mcnt !== 8'd0) begin n_fail++; $display("FAIL primed_gate_cnt: got %0d want 0", mcnt); end
    frc = 1'b1; primed = 1'b0;
    cycle();
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL force_unprimed: got %b want 0", trig); end
    frc = 1'b0; primed = 1'b1;
    cycle();
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL force_forgotten: got %b want 0", trig); end
    frc = 1'b1;
    cycle();
    frc = 1'b0;
    n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL force_primed: got %b want 1", trig); end
    arm = 1'b0; cycle();
  endtask

  task automatic test_edge();
    logic [7:0] seq [3];
    seq = '{8'h01, 8'h01, 8'h00};
    edge_mask = 8'h01; mask = 8'h00; count = 8'd1; primed = 1'b1;
    data = 8'h01; arm = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      data = seq[i];
      cycle();
      n_tests++; if (trig !== (i == 2)) begin n_fail++; $display("FAIL edge_trig[%0d]: got %b want %b", i, trig, i == 2); end
    end
    arm = 1'b0; cycle();
  endtask

  task automatic test_back_to_back();
    pattern = 8'hA5; mask = 8'hFF; edge_mask = 8'h00; count = 8'd1; primed = 1'b1;
    arm = 1'b1; data = 8'h00;
    cycle();
    data = 8'hA5; arm = 1'b0;
    cycle();
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL disarm_prio_trig: got %b want 0", trig); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL disarm_prio_armed: got %b want 0", armed); end
    arm = 1'b1; data = 8'h00;
    cycle();
    data = 8'hA5;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL fired_hold[%0d]: got %b want 1", i, trig); end
    end
    arm = 1'b0;
    cycle();
    arm = 1'b1; data = 8'h00;
    cycle();
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL rearm_armed: got %b want 1", armed); end
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rearm_trig: got %b want 0", trig); end
    n_tests++; if (mcnt !== 8'd0) begin n_fail++; $display("FAIL rearm_cnt: got %0d want 0", mcnt); end
  endtask

  task automatic test_async_reset();
    data = 8'hA5;
    cycle();
    n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL ar_prefire: got %b want 1", trig); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL ar_trig: got %b want 0", trig); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL ar_armed: got %b want 0", armed); end
    n_tests++; if (mcnt !== 8'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", mcnt); end
    #1 reset = 1'b0;
    data = 8'h00;
    cycle();
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL ar_rearm: got %b want 1", armed); end
    arm = 1'b0; cycle();
  endtask

  task automatic test_random();
    int shown = 0;
    reset = 1'b1; arm = 1'b0; frc = 1'b0;
    cycle();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      arm       = ($urandom_range(0, 15) != 0);
      primed    = ($urandom_range(0, 7) != 0);
      frc       = ($urandom_range(0, 40) == 0);
      pattern   = 8'($urandom);
      mask      = 8'($urandom) & 8'($urandom) & 8'($urandom);
      edge_mask = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      count     = 8'($urandom_range(0, 4));
      data      = ($urandom_range(0, 1) == 1) ? (m_pat ^ (8'h01 << $urandom_range(0, 7)))
                                               : (($urandom_range(0, 1) == 1) ? m_pat : 8'($urandom));
      model_step();
      cycle();
      n_tests++;
      if (trig !== (m_phase == 2) || armed !== (m_phase == 1) || int'(mcnt) != m_cnt) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL rand[%0d]: got trig=%b armed=%b cnt=%0d want trig=%b armed=%b cnt=%0d",
                   c, trig, armed, mcnt, m_phase == 2, m_phase == 1, m_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask_count();
    test_primed();
    test_edge();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
